correlator_accumulator: RTL and testbench

Integrate-and-dump stage directly upstream of the GPS Wishbone register interface. It accumulates per-sample early/prompt/late I/Q correlator products over a configurable number of C/A code epochs and dumps six 20-bit sums. It produces the `intg_ready` strobe that the register interface synchronises and edge-detects. It also flags acquisition when the dumped prompt magnitude exceeds the programmed `acq_threshold`.

---
 rtl/correlator_accumulator.sv | 205 ++++++++++++++++++++
 tb/tb_correlator_accumulator.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/correlator_accumulator.sv
// correlator_accumulator
//   Integrate-and-dump stage for six early/prompt/late I/Q correlator
//   products. Each product is summed into a saturating accumulator over
//   INTG_EPOCHS code epochs. At the end of the integration the sums are
//   dumped to the output registers and intg_ready is raised for READY_HOLD
//   cycles. One cycle after each dump the prompt magnitude is compared with
//   the programmed acquisition threshold.
//
// Ports
//   wb_clk_i, wb_rst_i      clock, asynchronous active-low reset
//   enable                  tracking enable; while low the accumulators and
//                           the epoch counter are held at zero
//   corr_valid              product inputs valid this cycle
//   *_i_in / *_q_in         signed IN_W correlator products
//   code_epoch              pulse on the last chip of a code period
//   acq_threshold           unsigned threshold, compared as {thr, 6'b0}
//   acq_restart             clears acq_complete, overrun, the accumulators
//                           and the epoch counter
//   *_idata / *_qdata       signed ACC_W dumped sums
//   intg_ready              dump strobe, high for READY_HOLD cycles
//   acq_complete            sticky acquisition flag
//   overrun                 sticky: a dump happened while intg_ready was high
module correlator_accumulator #(
  parameter int IN_W        = 4,
  parameter int ACC_W       = 20,
  parameter int INTG_EPOCHS = 1,
  parameter int READY_HOLD  = 4
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    enable,
  input  logic                    corr_valid,
  input  logic signed [IN_W-1:0]  early_i_in,
  input  logic signed [IN_W-1:0]  early_q_in,
  input  logic signed [IN_W-1:0]  prompt_i_in,
  input  logic signed [IN_W-1:0]  prompt_q_in,
  input  logic signed [IN_W-1:0]  late_i_in,
  input  logic signed [IN_W-1:0]  late_q_in,
  input  logic                    code_epoch,
  input  logic [14:0]             acq_threshold,
  input  logic                    acq_restart,
  output logic signed [ACC_W-1:0] early_idata,
  output logic signed [ACC_W-1:0] early_qdata,
  output logic signed [ACC_W-1:0] prompt_idata,
  output logic signed [ACC_W-1:0] prompt_qdata,
  output logic signed [ACC_W-1:0] late_idata,
  output logic signed [ACC_W-1:0] late_qdata,
  output logic                    intg_ready,
  output logic                    acq_complete,
  output logic                    overrun
);

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam int                      HOLD_W  = $clog2(READY_HOLD);
  localparam logic [ACC_W:0]          ONE_W   = 1;

  logic signed [IN_W-1:0]  prod      [6];
  logic signed [ACC_W-1:0] dump_data [6];
  logic [4:0]              epoch_cnt_reg;
  logic [HOLD_W-1:0]       hold_cnt_reg;
  logic                    ready_reg;
  logic                    overrun_reg;
  logic                    acq_reg;
  logic                    detect_pending_reg;
  logic                    dump;

  assign prod[0] = early_i_in;
  assign prod[1] = early_q_in;
  assign prod[2] = prompt_i_in;
  assign prod[3] = prompt_q_in;
  assign prod[4] = late_i_in;
  assign prod[5] = late_q_in;

  // A restart in the same cycle suppresses the dump.
  assign dump = enable && code_epoch && !acq_restart &&
                (epoch_cnt_reg == 5'(INTG_EPOCHS - 1));

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      epoch_cnt_reg <= '0;
    end else if (!enable || acq_restart || dump) begin
      epoch_cnt_reg <= '0;
    end else if (code_epoch) begin
      epoch_cnt_reg <= epoch_cnt_reg + 5'd1;
    end
  end

  for (genvar gi = 0; gi < 6; gi++) begin : g_chan
    logic signed [ACC_W-1:0] acc_reg;
    logic signed [ACC_W-1:0] dump_reg;
    logic                    clamp_reg;
    logic signed [ACC_W:0]   prod_ext;
    logic signed [ACC_W:0]   wide_sum;
    logic signed [ACC_W-1:0] sum_next;
    logic                    clamp_next;

    assign prod_ext = corr_valid ? {{(ACC_W+1-IN_W){prod[gi][IN_W-1]}}, prod[gi]} : '0;
    assign wide_sum = {acc_reg[ACC_W-1], acc_reg} + prod_ext;

    // Overflow shows up as disagreement between the two top bits of the
    // one-bit-wider sum. Once clamped, the accumulator ignores further
    // samples until it is cleared, so it cannot walk back off the rail.
    always_comb begin
      sum_next   = wide_sum[ACC_W-1:0];
      clamp_next = 1'b0;
      if (clamp_reg) begin
        sum_next   = acc_reg;
        clamp_next = 1'b1;
      end else if (wide_sum[ACC_W] != wide_sum[ACC_W-1]) begin
        sum_next   = wide_sum[ACC_W] ? ACC_MIN : ACC_MAX;
        clamp_next = 1'b1;
      end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
        acc_reg   <= '0;
        clamp_reg <= 1'b0;
      end else if (!enable || acq_restart || dump) begin
        acc_reg   <= '0;
        clamp_reg <= 1'b0;
      end else if (corr_valid) begin
        acc_reg   <= sum_next;
        clamp_reg <= clamp_next;
      end
    end

    // The dump captures the sum including the current-cycle sample.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
        dump_reg <= '0;
      end else if (dump) begin
        dump_reg <= sum_next;
      end
    end

    assign dump_data[gi] = dump_reg;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      ready_reg    <= 1'b0;
      hold_cnt_reg <= '0;
      overrun_reg  <= 1'b0;
    end else begin
      if (dump) begin
        ready_reg    <= 1'b1;
        hold_cnt_reg <= HOLD_W'(READY_HOLD - 1);
      end else if (ready_reg) begin
        if (hold_cnt_reg == '0) begin
          ready_reg <= 1'b0;
        end else begin
          hold_cnt_reg <= hold_cnt_reg - 1'b1;
        end
      end
      if (acq_restart) begin
        overrun_reg <= 1'b0;
      end else if (dump && ready_reg) begin
        overrun_reg <= 1'b1;
      end
    end
  end

  // Magnitude is taken from the freshly loaded output registers, so the
  // detect runs the cycle after the dump.
  logic signed [ACC_W:0] pi_ext;
  logic signed [ACC_W:0] pq_ext;
  logic [ACC_W:0]        abs_i;
  logic [ACC_W:0]        abs_q;
  logic [ACC_W:0]        mag;
  logic [ACC_W:0]        thr_ext;

  assign pi_ext  = {dump_data[2][ACC_W-1], dump_data[2]};
  assign pq_ext  = {dump_data[3][ACC_W-1], dump_data[3]};
  assign abs_i   = pi_ext[ACC_W] ? ((~pi_ext) + ONE_W) : pi_ext;
  assign abs_q   = pq_ext[ACC_W] ? ((~pq_ext) + ONE_W) : pq_ext;
  assign mag     = abs_i + abs_q;
  assign thr_ext = (ACC_W+1)'({acq_threshold, 6'b0});

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      detect_pending_reg <= 1'b0;
      acq_reg            <= 1'b0;
    end else begin
      detect_pending_reg <= dump;
      if (acq_restart) begin
        acq_reg <= 1'b0;
      end else if (detect_pending_reg && (mag >= thr_ext)) begin
        acq_reg <= 1'b1;
      end
    end
  end

  assign early_idata  = dump_data[0];
  assign early_qdata  = dump_data[1];
  assign prompt_idata = dump_data[2];
  assign prompt_qdata = dump_data[3];
  assign late_idata   = dump_data[4];
  assign late_qdata   = dump_data[5];
  assign intg_ready   = ready_reg;
  assign acq_complete = acq_reg;
  assign overrun      = overrun_reg;

endmodule

// File: tb/tb_correlator_accumulator.sv
// Bench for correlator_accumulator. Two instances share most inputs:
// u_dut1 integrates over one epoch, u_dut3 over three; u_dut3 has its own
// code_epoch and late_q inputs so both saturation rails can be exercised in
// one run. Expected dump contents are queued when the stimulus is driven and
// popped when the dump appears on the outputs.
module tb_correlator_accumulator;

  typedef logic [5:0][19:0] sums_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic              corr_valid;
  logic signed [3:0] prod_in [6];
  logic signed [3:0] lq_b;
  logic              epoch_a;
  logic              epoch_b;
  logic [14:0]       thr;
  logic              acq_restart;

  logic [19:0] out1 [6];
  logic [19:0] out3 [6];
  logic        ready1, acq1, ovr1;
  logic        ready3, acq3, ovr3;

  sums_t exp_q [$];
  sums_t exp_v;
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  correlator_accumulator #(.IN_W(4), .ACC_W(20), .INTG_EPOCHS(1), .READY_HOLD(4)) u_dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .enable(enable), .corr_valid(corr_valid),
    .early_i_in(prod_in[0]), .early_q_in(prod_in[1]),
    .prompt_i_in(prod_in[2]), .prompt_q_in(prod_in[3]),
    .late_i_in(prod_in[4]), .late_q_in(prod_in[5]),
    .code_epoch(epoch_a), .acq_threshold(thr), .acq_restart(acq_restart),
    .early_idata(out1[0]), .early_qdata(out1[1]),
    .prompt_idata(out1[2]), .prompt_qdata(out1[3]),
    .late_idata(out1[4]), .late_qdata(out1[5]),
    .intg_ready(ready1), .acq_complete(acq1), .overrun(ovr1)
  );

  correlator_accumulator #(.IN_W(4), .ACC_W(20), .INTG_EPOCHS(3), .READY_HOLD(4)) u_dut3 (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .enable(enable), .corr_valid(corr_valid),
    .early_i_in(prod_in[0]), .early_q_in(prod_in[1]),
    .prompt_i_in(prod_in[2]), .prompt_q_in(prod_in[3]),
    .late_i_in(prod_in[4]), .late_q_in(lq_b),
    .code_epoch(epoch_b), .acq_threshold(thr), .acq_restart(acq_restart),
    .early_idata(out3[0]), .early_qdata(out3[1]),
    .prompt_idata(out3[2]), .prompt_qdata(out3[3]),
    .late_idata(out3[4]), .late_qdata(out3[5]),
    .intg_ready(ready3), .acq_complete(acq3), .overrun(ovr3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_prod(input int a, input int b, input int c,
                          input int d, input int e, input int f);
    prod_in[0] = 4'(a); prod_in[1] = 4'(b); prod_in[2] = 4'(c);
    prod_in[3] = 4'(d); prod_in[4] = 4'(e); prod_in[5] = 4'(f);
  endtask

  task automatic push_exp(input int a, input int b, input int c,
                          input int d, input int e, input int f);
    sums_t s;
    s[0] = 20'(a); s[1] = 20'(b); s[2] = 20'(c);
    s[3] = 20'(d); s[4] = 20'(e); s[5] = 20'(f);
    exp_q.push_back(s);
  endtask

  task automatic idle(input int n);
    enable = 1'b0; corr_valid = 1'b0; epoch_a = 1'b0; epoch_b = 1'b0;
    acq_restart = 1'b0; lq_b = '0;
    set_prod(0, 0, 0, 0, 0, 0);
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (out1[k] !== 20'd0 || out3[k] !== 20'd0) begin
        errors++;
        $display("FAIL reset_data ch%0d got %0d/%0d want 0", k, out1[k], out3[k]);
      end
    end
    checks++;
    if ({ready1, acq1, ovr1, ready3, acq3, ovr3} !== 6'b0) begin
      errors++;
      $display("FAIL reset_status got %b want 000000", {ready1, acq1, ovr1, ready3, acq3, ovr3});
    end
    $display("txn reset: outputs idle");
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_dump();
    idle(6);
    enable = 1'b1; corr_valid = 1'b1;
    set_prod(0, 0, 3, -2, 0, 0);
    for (int i = 0; i < 10; i++) begin
      epoch_a = (i == 9);
      if (i == 9) push_exp(0, 0, 30, -20, 0, 0);
      tick();
    end
    epoch_a = 1'b0; corr_valid = 1'b0;
    exp_v = exp_q.pop_front();
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (out1[k] !== exp_v[k]) begin
        errors++;
        $display("FAIL single_dump ch%0d got %0d want %0d", k, $signed(out1[k]), $signed(exp_v[k]));
      end
    end
    $display("txn single_dump: prompt %0d / %0d", $signed(out1[2]), $signed(out1[3]));
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (ready1 !== 1'b1) begin
        errors++;
        $display("FAIL single_ready_high cycle %0d got %b want 1", j, ready1);
      end
      tick();
    end
    checks++;
    if (ready1 !== 1'b0) begin
      errors++;
      $display("FAIL single_ready_fall got %b want 0", ready1);
    end
    corr_valid = 1'b1;
    set_prod(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      epoch_a = (i == 4);
      if (i == 4) push_exp(0, 0, 5, 0, 0, 0);
      tick();
    end
    epoch_a = 1'b0; corr_valid = 1'b0;
    exp_v = exp_q.pop_front();
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (out1[k] !== exp_v[k]) begin
        errors++;
        $display("FAIL fresh_start ch%0d got %0d want %0d", k, $signed(out1[k]), $signed(exp_v[k]));
      end
    end
    $display("txn fresh_start: prompt_i %0d", $signed(out1[2]));
  endtask

  task automatic test_multi_epoch();
    idle(6);
    enable = 1'b1; corr_valid = 1'b1;
    set_prod(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 300; i++) begin
      epoch_b = ((i % 100) == 99);
      if (i == 299) push_exp(300, 0, 0, 0, 0, 0);
      tick();
      if (i == 99 || i == 199) begin
        checks++;
        if (ready3 !== 1'b0) begin
          errors++;
          $display("FAIL multi_early_ready at cycle %0d got %b want 0", i, ready3);
        end
      end
    end
    epoch_b = 1'b0; corr_valid = 1'b0;
    exp_v = exp_q.pop_front();
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (out3[k] !== exp_v[k]) begin
        errors++;
        $display("FAIL multi_epoch ch%0d got %0d want %0d", k, $signed(out3[k]), $signed(exp_v[k]));
      end
    end
    checks++;
    if (ready3 !== 1'b1) begin
      errors++;
      $display("FAIL multi_ready got %b want 1", ready3);
    end
    $display("txn multi_epoch: early_i %0d", $signed(out3[0]));
  endtask

  task automatic test_saturation();
    localparam int N = 75000;
    idle(6);
    enable = 1'b1; corr_valid = 1'b1;
    set_prod(0, 0, 0, 0, 0, 7);
    lq_b = -4'sd8;
    push_exp(0, 0, 0, 0, 0, 524287);
    push_exp(0, 0, 0, 0, 0, -524288);
    for (int i = 0; i < N; i++) begin
      // Small negative samples after clamping must not pull the sum back.
      prod_in[5] = (i >= N - 10) ? -4'sd1 : 4'sd7;
      epoch_a = (i == N - 1);
      epoch_b = (i >= N - 3);
      tick();
    end
    epoch_a = 1'b0; epoch_b = 1'b0; corr_valid = 1'b0;
    exp_v = exp_q.pop_front();
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (out1[k] !== exp_v[k]) begin
        errors++;
        $display("FAIL sat_pos ch%0d got %0d want %0d", k, $signed(out1[k]), $signed(exp_v[k]));
      end
    end
    exp_v = exp_q.pop_front();
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (out3[k] !== exp_v[k]) begin
        errors++;
        $display("FAIL sat_neg ch%0d got %0d want %0d", k, $signed(out3[k]), $signed(exp_v[k]));
      end
    end
    $display("txn saturation: late_q %0d / %0d", $signed(out1[5]), $signed(out3[5]));
  endtask

  task automatic test_acquisition();
    for (int pass = 0; pass < 2; pass++) begin
      idle(6);
      thr = (pass == 0) ? 15'd1 : 15'd2;
      enable = 1'b1; corr_valid = 1'b1;
      set_prod(0, 0, 4, -3, 0, 0);
      for (int i = 0; i < 10; i++) begin
        epoch_a = (i == 9);
        if (i == 9) push_exp(0, 0, 40, -30, 0, 0);
        tick();
      end
      epoch_a = 1'b0; corr_valid = 1'b0;
      exp_v = exp_q.pop_front();
      for (int k = 2; k < 4; k++) begin
        checks++;
        if (out1[k] !== exp_v[k]) begin
          errors++;
          $display("FAIL acq_data pass%0d ch%0d got %0d want %0d", pass, k, $signed(out1[k]), $signed(exp_v[k]));
        end
      end
      checks++;
      if (acq1 !== 1'b0) begin
        errors++;
        $display("FAIL acq_at_dump pass%0d got %b want 0", pass, acq1);
      end
      tick();
      checks++;
      if (acq1 !== (pass == 0)) begin
        errors++;
        $display("FAIL acq_after_dump thr %0d got %b want %b", thr, acq1, pass == 0);
      end
      $display("txn acquisition: thr %0d acq %b", thr, acq1);
      acq_restart = 1'b1;
      tick();
      acq_restart = 1'b0;
      checks++;
      if (acq1 !== 1'b0) begin
        errors++;
        $display("FAIL acq_restart pass%0d got %b want 0", pass, acq1);
      end
    end
    thr = 15'h7FFF;
  endtask

  task automatic test_overrun();
    idle(6);
    enable = 1'b1; corr_valid = 1'b1;
    set_prod(2, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      epoch_a = (i == 4);
      if (i == 4) push_exp(10, 0, 0, 0, 0, 0);
      tick();
    end
    exp_v = exp_q.pop_front();
    checks++;
    if (out1[0] !== exp_v[0] || ovr1 !== 1'b0) begin
      errors++;
      $display("FAIL overrun_first got %0d ovr %b want %0d ovr 0", $signed(out1[0]), ovr1, $signed(exp_v[0]));
    end
    set_prod(3, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      epoch_a = (i == 1);
      if (i == 1) push_exp(6, 0, 0, 0, 0, 0);
      tick();
    end
    epoch_a = 1'b0; corr_valid = 1'b0;
    exp_v = exp_q.pop_front();
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (out1[k] !== exp_v[k]) begin
        errors++;
        $display("FAIL overrun_second ch%0d got %0d want %0d", k, $signed(out1[k]), $signed(exp_v[k]));
      end
    end
    checks++;
    if (ovr1 !== 1'b1) begin
      errors++;
      $display("FAIL overrun_flag got %b want 1", ovr1);
    end
    $display("txn overrun: early_i %0d overrun %b", $signed(out1[0]), ovr1);
    repeat (3) tick();
    checks++;
    if (ready1 !== 1'b1) begin
      errors++;
      $display("FAIL overrun_ready_hold got %b want 1", ready1);
    end
    tick();
    checks++;
    if (ready1 !== 1'b0) begin
      errors++;
      $display("FAIL overrun_ready_fall got %b want 0", ready1);
    end
    acq_restart = 1'b1;
    tick();
    acq_restart = 1'b0;
    checks++;
    if (ovr1 !== 1'b0 || out1[0] !== 20'd6) begin
      errors++;
      $display("FAIL overrun_clear got ovr %b data %0d want ovr 0 data 6", ovr1, $signed(out1[0]));
    end
  endtask

  task automatic test_restart_wins();
    idle(6);
    enable = 1'b1; corr_valid = 1'b1;
    set_prod(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      epoch_a = (i == 2);
      acq_restart = (i == 2);
      tick();
    end
    epoch_a = 1'b0; acq_restart = 1'b0;
    checks++;
    if (ready1 !== 1'b0 || out1[0] !== 20'd6) begin
      errors++;
      $display("FAIL restart_blocks_dump got ready %b data %0d want ready 0 data 6", ready1, $signed(out1[0]));
    end
    epoch_a = 1'b1;
    push_exp(1, 0, 0, 0, 0, 0);
    tick();
    epoch_a = 1'b0; corr_valid = 1'b0;
    exp_v = exp_q.pop_front();
    checks++;
    if (out1[0] !== exp_v[0] || ready1 !== 1'b1) begin
      errors++;
      $display("FAIL restart_then_dump got %0d ready %b want %0d ready 1", $signed(out1[0]), ready1, $signed(exp_v[0]));
    end
    $display("txn restart_wins: early_i %0d", $signed(out1[0]));
  endtask

  task automatic test_reset_mid();
    idle(6);
    enable = 1'b1; corr_valid = 1'b1;
    set_prod(5, 0, 0, 0, 0, 0);
    repeat (7) tick();
    #1 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (out1[k] !== 20'd0) begin
        errors++;
        $display("FAIL reset_mid ch%0d got %0d want 0", k, $signed(out1[k]));
      end
    end
    checks++;
    if ({ready1, acq1, ovr1} !== 3'b0) begin
      errors++;
      $display("FAIL reset_mid_status got %b want 000", {ready1, acq1, ovr1});
    end
    #2 rst_n = 1'b1;
    set_prod(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      epoch_a = (i == 3);
      if (i == 3) push_exp(4, 0, 0, 0, 0, 0);
      tick();
    end
    epoch_a = 1'b0; corr_valid = 1'b0;
    exp_v = exp_q.pop_front();
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (out1[k] !== exp_v[k]) begin
        errors++;
        $display("FAIL post_reset_dump ch%0d got %0d want %0d", k, $signed(out1[k]), $signed(exp_v[k]));
      end
    end
    $display("txn reset_mid: early_i %0d", $signed(out1[0]));
  endtask

  initial begin
    thr = 15'h7FFF;
    lq_b = '0;
    test_reset();
    test_single_dump();
    test_multi_epoch();
    test_saturation();
    test_acquisition();
    test_overrun();
    test_restart_wins();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
